// File: rtl/bht_ghr_index.sv
// bht_ghr_index: index-generation stage in front of the BHT.
// Hashes the fetch PC with a speculative global history register (gshare) to form
// the BHT index, shifts each BHT prediction into the history, and keeps a FIFO of
// pre-shift history snapshots so the history can be repaired on a mispredict.
// Build option: define GHR_FOLD_EN to XOR the folded history into the index;
// leave it undefined for a pure bimodal index (history tracking still runs).
// Index width comes from `BHT_IDX_WIDTH.

`ifndef BHT_IDX_WIDTH
`define BHT_IDX_WIDTH 4
`endif

module bht_ghr_index #(
  parameter int PC_WIDTH   = 32,
  parameter int GHR_LEN    = 16,
  parameter int CKPT_DEPTH = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          pc_valid_i,
  input  logic [PC_WIDTH-1:0]           pc_i,
  output logic                          ready_o,
  output logic [`BHT_IDX_WIDTH-1:0]     idx_o,
  output logic                          idx_valid_o,
  input  logic                          pred_valid_i,
  input  logic                          pred_taken_i,
  input  logic                          res_valid_i,
  input  logic                          res_mispred_i,
  input  logic                          res_taken_i,
  output logic [GHR_LEN-1:0]            ghr_o,
  output logic [$clog2(CKPT_DEPTH):0]   ckpt_count_o,
  output logic                          res_err_o
);

  localparam int IDX_W = `BHT_IDX_WIDTH;
  localparam int PW    = $clog2(CKPT_DEPTH);
  localparam int CW    = PW + 1;

  logic [GHR_LEN-1:0] ghr;
  logic [GHR_LEN-1:0] ckpt_mem [CKPT_DEPTH];
  logic [PW-1:0]      rd_ptr;
  logic [PW-1:0]      wr_ptr;
  logic [CW-1:0]      count;
  logic [IDX_W-1:0]   idx;
  logic               idx_valid;
  logic               res_err;

  logic               ready;
  logic               full;
  logic               res_ok;
  logic               mispred;
  logic               pop;
  logic               push;
  logic               accept;
  logic [IDX_W-1:0]   pc_idx;
  logic [IDX_W-1:0]   hash;
  logic [GHR_LEN-1:0] oldest;

`ifdef GHR_FOLD_EN
  localparam int NSLICE = (GHR_LEN + IDX_W - 1) / IDX_W;

  // XOR of consecutive IDX_W-bit slices from bit 0 upward; top slice zero-padded.
  function automatic logic [IDX_W-1:0] fold(input logic [GHR_LEN-1:0] g);
    logic [NSLICE*IDX_W-1:0] padded;
    logic [IDX_W-1:0]        acc;
    padded              = '0;
    padded[GHR_LEN-1:0] = g;
    acc                 = '0;
    for (int i = 0; i < NSLICE; i++) begin
      acc = acc ^ padded[i*IDX_W +: IDX_W];
    end
    return acc;
  endfunction
`endif

  // PC bits outside the index field do not take part in the hash.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc_i[PC_WIDTH-1:IDX_W+2], pc_i[1:0]};

  // Control decode: resolve, push/pop qualification, accept and index hash.
  always_comb begin
    // NOTE: every signal gets a value at the top so no path can infer a latch.
    ready   = (count + CW'(idx_valid)) < CW'(CKPT_DEPTH);
    full    = (count == CW'(CKPT_DEPTH));
    res_ok  = res_valid_i && (count != '0);
    mispred = res_ok && res_mispred_i;
    pop     = res_ok && !res_mispred_i;
    // A full FIFO can still take a push when the oldest entry leaves in the same cycle.
    push    = pred_valid_i && !mispred && (!full || pop);
    accept  = pc_valid_i && ready && !mispred;
    oldest  = ckpt_mem[rd_ptr];
    pc_idx  = pc_i[IDX_W+1:2];
`ifdef GHR_FOLD_EN
    hash    = pc_idx ^ fold(ghr);
`else
    hash    = pc_idx;
`endif
  end

  // Speculative history, FIFO pointers/occupancy, index register and error flag.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst_i) begin
      ghr       <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      idx       <= '0;
      idx_valid <= 1'b0;
      res_err   <= 1'b0;
    end else begin
      idx_valid <= accept;
      if (accept) begin
        idx <= hash;
      end
      if (res_valid_i && (count == '0)) begin
        res_err <= 1'b1;
      end
      if (mispred) begin
        // Rebuild from the snapshot taken before the mispredicted branch shifted in.
        ghr    <= {oldest[GHR_LEN-2:0], res_taken_i};
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          ghr    <= {ghr[GHR_LEN-2:0], pred_taken_i};
          wr_ptr <= wr_ptr + PW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Checkpoint storage: snapshot of the history before each prediction shift.
  always_ff @(posedge clk_i) begin
    // NOTE: storage is left unreset; an entry is only ever read after it was written.
    if (!rst_i && push) begin
      ckpt_mem[wr_ptr] <= ghr;
    end
  end

  // A prediction arriving with no room and no pop means upstream lost track of credits.
  assert property (@(posedge clk_i) disable iff (rst_i)
    !(pred_valid_i && !mispred && full && !pop));

  assign ready_o      = ready;
  assign idx_o        = idx;
  assign idx_valid_o  = idx_valid;
  assign ghr_o        = ghr;
  assign ckpt_count_o = count;
  assign res_err_o    = res_err;

endmodule

// File: tb/tb_bht_ghr_index.sv
// Testbench for bht_ghr_index: directed vectors, expected indices queued at issue
// time and compared by an independent monitor whenever idx_valid_o is high.

`ifndef BHT_IDX_WIDTH
`define BHT_IDX_WIDTH 4
`endif

module tb_bht_ghr_index;

  localparam int PC_WIDTH   = 32;
  localparam int GHR_LEN    = 8;
  localparam int CKPT_DEPTH = 4;
  localparam int IDX_W      = `BHT_IDX_WIDTH;
  localparam int CW         = $clog2(CKPT_DEPTH) + 1;

  logic                clk = 1'b0;
  logic                rst_i = 1'b1;
  logic                pc_valid_i = 1'b0;
  logic [PC_WIDTH-1:0] pc_i = '0;
  logic                ready_o;
  logic [IDX_W-1:0]    idx_o;
  logic                idx_valid_o;
  logic                pred_valid_i = 1'b0;
  logic                pred_taken_i = 1'b0;
  logic                res_valid_i = 1'b0;
  logic                res_mispred_i = 1'b0;
  logic                res_taken_i = 1'b0;
  logic [GHR_LEN-1:0]  ghr_o;
  logic [CW-1:0]       ckpt_count_o;
  logic                res_err_o;

  always #5 clk = ~clk;

  bht_ghr_index #(
    .PC_WIDTH  (PC_WIDTH),
    .GHR_LEN   (GHR_LEN),
    .CKPT_DEPTH(CKPT_DEPTH)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .pc_valid_i   (pc_valid_i),
    .pc_i         (pc_i),
    .ready_o      (ready_o),
    .idx_o        (idx_o),
    .idx_valid_o  (idx_valid_o),
    .pred_valid_i (pred_valid_i),
    .pred_taken_i (pred_taken_i),
    .res_valid_i  (res_valid_i),
    .res_mispred_i(res_mispred_i),
    .res_taken_i  (res_taken_i),
    .ghr_o        (ghr_o),
    .ckpt_count_o (ckpt_count_o),
    .res_err_o    (res_err_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [IDX_W-1:0]   exp_q [$];
  logic [GHR_LEN-1:0] m_ckpt [$];
  logic [GHR_LEN-1:0] m_ghr = '0;
  logic               m_idx_valid = 1'b0;
  logic               m_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Bit i of the history lands on index bit i mod IDX_W.
  function automatic logic [IDX_W-1:0] exp_fold(input logic [GHR_LEN-1:0] g);
    logic [IDX_W-1:0] r;
    r = '0;
`ifdef GHR_FOLD_EN
    for (int i = 0; i < GHR_LEN; i++) r[i % IDX_W] = r[i % IDX_W] ^ g[i];
`endif
    return r;
  endfunction

  task automatic check_state(input string tag);
    check({tag, " ghr_o"}, ghr_o, m_ghr);
    check({tag, " ckpt_count_o"}, ckpt_count_o, m_ckpt.size());
    check({tag, " ready_o"}, ready_o, (m_ckpt.size() + int'(m_idx_valid)) < CKPT_DEPTH);
    check({tag, " idx_valid_o"}, idx_valid_o, m_idx_valid);
    check({tag, " res_err_o"}, res_err_o, m_err);
  endtask

  task automatic clear_inputs();
    pc_valid_i    = 1'b0;
    pc_i          = '0;
    pred_valid_i  = 1'b0;
    pred_taken_i  = 1'b0;
    res_valid_i   = 1'b0;
    res_mispred_i = 1'b0;
    res_taken_i   = 1'b0;
  endtask

  // One cycle of stimulus; the reference model advances alongside.
  task automatic step(input string tag, input logic pv, input logic [31:0] pc,
                      input logic prv, input logic prt,
                      input logic rv, input logic rm, input logic rt);
    logic [31:0] pc_loc;
    logic m_ready, m_mis, m_acc, m_pop, m_full;
    pc_loc  = pc;
    m_ready = (m_ckpt.size() + int'(m_idx_valid)) < CKPT_DEPTH;
    m_mis   = rv && (m_ckpt.size() != 0) && rm;
    m_pop   = rv && (m_ckpt.size() != 0) && !rm;
    m_full  = (m_ckpt.size() == CKPT_DEPTH);
    m_acc   = pv && m_ready && !m_mis;
    pc_valid_i    = pv;
    pc_i          = pc;
    pred_valid_i  = prv;
    pred_taken_i  = prt;
    res_valid_i   = rv;
    res_mispred_i = rm;
    res_taken_i   = rt;
    if (m_acc) exp_q.push_back(pc_loc[IDX_W+1:2] ^ exp_fold(m_ghr));
    @(posedge clk);
    if (rv && (m_ckpt.size() == 0)) m_err = 1'b1;
    if (m_mis) begin
      m_ghr = {m_ckpt[0][GHR_LEN-2:0], rt};
      m_ckpt.delete();
    end else begin
      if (m_pop) void'(m_ckpt.pop_front());
      if (prv && (!m_full || m_pop)) begin
        m_ckpt.push_back(m_ghr);
        m_ghr = {m_ghr[GHR_LEN-2:0], prt};
      end
    end
    m_idx_valid = m_acc;
    #1;
    clear_inputs();
    check_state(tag);
  endtask

  task automatic do_reset(input string tag, input int n);
    rst_i = 1'b1;
    clear_inputs();
    repeat (n) @(posedge clk);
    m_ghr = '0;
    m_ckpt.delete();
    m_idx_valid = 1'b0;
    m_err = 1'b0;
    #1;
    rst_i = 1'b0;
    exp_q.delete();
    check_state(tag);
    check({tag, " idx_o"}, idx_o, 0);
  endtask

  // Monitor: every presented index must match the oldest queued expectation.
  always @(negedge clk) begin
    if (idx_valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected idx_o: got 0x%0h, expected no valid index", idx_o);
      end else begin
        check("idx_o", idx_o, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset("reset", 2);

    // First lookup from an empty history: 0x34 -> index 0xD.
    step("pc34", 1, 32'h34, 0, 0, 0, 0, 0);
    check("pc34 ready_o after accept", ready_o, 1);

    // Taken, not-taken, taken from zero history.
    step("pred1", 0, 0, 1, 1, 0, 0, 0);
    step("pred0", 0, 0, 1, 0, 0, 0, 0);
    step("pred1b", 0, 0, 1, 1, 0, 0, 0);
    check("ghr after T,N,T", ghr_o, 8'h05);
    check("count after 3 preds", ckpt_count_o, 3);

    // Lookup with history 0x05 (0x8 with folding, 0xD bimodal).
    step("pc34_hist", 1, 32'h34, 0, 0, 0, 0, 0);
    step("idle1", 0, 0, 0, 0, 0, 0, 0);

    // Mispredict on oldest (snapshot 0x00), actual not-taken; same-cycle pc/pred ignored.
    step("mispred", 1, 32'h44, 1, 1, 1, 1, 0);
    check("ghr after mispred", ghr_o, 8'h00);
    check("count after mispred", ckpt_count_o, 0);
    check("idx_valid after mispred", idx_valid_o, 0);

    // Fill the FIFO: history 0 -> 1 -> 3 -> 6 -> 0xD.
    step("fill0", 0, 0, 1, 1, 0, 0, 0);
    step("fill1", 0, 0, 1, 1, 0, 0, 0);
    step("fill2", 0, 0, 1, 0, 0, 0, 0);
    step("fill3", 0, 0, 1, 1, 0, 0, 0);
    check("count full", ckpt_count_o, 4);
    check("ready when full", ready_o, 0);
    step("pc_when_full", 1, 32'h40, 0, 0, 0, 0, 0);

    step("resolve_ok", 0, 0, 0, 0, 1, 0, 0);
    check("count after correct resolve", ckpt_count_o, 3);
    check("ghr after correct resolve", ghr_o, 8'h0D);

    // Refill, then push + correct resolve together while full (slot reuse across wrap).
    step("refill", 0, 0, 1, 1, 0, 0, 0);
    check("ghr after refill", ghr_o, 8'h1B);
    step("push_pop_full", 0, 0, 1, 0, 1, 0, 0);
    check("count push+pop full", ckpt_count_o, 4);
    check("ghr push+pop full", ghr_o, 8'h36);
    // Oldest remaining snapshot is 0x03; mispredict taken gives 0x07.
    step("mispred_wrap", 0, 0, 0, 0, 1, 1, 1);
    check("ghr after wrap mispred", ghr_o, 8'h07);

    // Resolve with an empty FIFO: sticky error, mispredict ignored, pc still accepted.
    step("res_empty", 0, 0, 0, 0, 1, 0, 0);
    check("res_err set", res_err_o, 1);
    step("mis_empty", 1, 32'h10, 0, 0, 1, 1, 1);
    check("ghr kept on empty mispred", ghr_o, 8'h07);
    step("idle2", 0, 0, 0, 0, 0, 0, 0);
    check("res_err sticky", res_err_o, 1);

    // Mid-stream reset.
    step("pre_rst_p0", 0, 0, 1, 1, 0, 0, 0);
    step("pre_rst_p1", 0, 0, 1, 1, 0, 0, 0);
    step("pre_rst_pc", 1, 32'h34, 0, 0, 0, 0, 0);
    do_reset("mid_reset", 1);

    step("post_rst_pc", 1, 32'h34, 0, 0, 0, 0, 0);
    step("idle3", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    check("scoreboard drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
